// File: rtl/iq_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iq_packer_pkg
// Description : Shared types and helpers for the I/Q frame packer.
//               - packer_state_t : packer FSM state encoding
//               - OVF_CNT_W      : width of the saturating overflow counter
//               - build_header   : forms the {sync, sequence} header word
// Revision    : 1.0 - initial release
// ============================================================================
package iq_packer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } packer_state_t;

  localparam int OVF_CNT_W = 16;

  // Widest header word the helper can form; callers cast the result down
  // to their FIFO word width.
  localparam int HDR_MAX_W = 64;

  // Header = {sync, seq}, each field masked to half_w bits, so the sync
  // pattern is zero-extended or truncated to fit the upper half.
  function automatic logic [HDR_MAX_W-1:0] build_header(
    input logic [31:0] sync,
    input logic [31:0] seq,
    input int unsigned half_w
  );
    logic [HDR_MAX_W-1:0] mask;
    mask = (64'd1 << half_w) - 64'd1;
    return ((64'(sync) & mask) << half_w) | (64'(seq) & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iq_test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : iq_test_pattern_gen
// Description : Optional data substitution for the I/Q frame packer. With
//               test_mode high the sample is replaced by I = in-frame sample
//               index (8-bit wrapped, resized to HALF_W) and Q = ~I;
//               otherwise the sample passes through unchanged.
// Ports       : test_mode  in  1       substitute the test pattern
//               sample_idx in  8       in-frame sample index (wrapped)
//               in_i/in_q  in  HALF_W  live sample
//               out_i/out_q out HALF_W selected sample
// Revision    : 1.0 - initial release
// ============================================================================
module iq_test_pattern_gen #(
  parameter int unsigned HALF_W = 8
) (
  input  logic              test_mode,
  input  logic [7:0]        sample_idx,
  input  logic [HALF_W-1:0] in_i,
  input  logic [HALF_W-1:0] in_q,
  output logic [HALF_W-1:0] out_i,
  output logic [HALF_W-1:0] out_q
);

  logic [HALF_W-1:0] pat_i;

  // Size cast zero-extends or truncates the 8-bit index to the lane width.
  assign pat_i = HALF_W'(sample_idx);
  assign out_i = test_mode ? pat_i : in_i;
  assign out_q = test_mode ? ~pat_i : in_q;

endmodule
`default_nettype wire

// File: rtl/iq_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : iq_frame_packer
// Description : Packs I/Q sample pairs into {Q,I} FIFO words for the FT600
//               write FIFO. Each frame is one header word {SYNC, frame_seq}
//               followed by FRAME_LEN data words. On FIFO overflow the rest of
//               the frame is discarded so the host resynchronises on a header.
// Build macro : IQ_PACKER_TEST_PATTERN_EN - adds the test_mode port and the
//               iq_test_pattern_gen data substitution.
// Ports       : clk        in   1        sample / FIFO write clock
//               reset_n    in   1        synchronous, active-low reset
//               enable     in   1        streaming enable
//               s_valid    in   1        one-cycle sample strobe
//               s_i, s_q   in   W/2      I and Q samples
//               fifo_full  in   1        write FIFO full flag
//               fifo_wr_en out  1        registered FIFO write strobe
//               fifo_wdata out  W        registered FIFO write data
//               ovf_cnt    out  16       saturating dropped-word counter
//               frame_seq  out  W/2      sequence number of current frame
//               test_mode  in   1        (macro only) emit test pattern
// Revision    : 1.0 - initial release
// ============================================================================
module iq_frame_packer
  import iq_packer_pkg::*;
#(
  parameter int unsigned IQ_PAIR_WIDTH = 16,
  parameter int unsigned FRAME_LEN     = 1024,
  parameter int unsigned SYNC_PATTERN  = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       s_valid,
  input  logic [IQ_PAIR_WIDTH/2-1:0] s_i,
  input  logic [IQ_PAIR_WIDTH/2-1:0] s_q,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [IQ_PAIR_WIDTH-1:0]   fifo_wdata,
  output logic [OVF_CNT_W-1:0]       ovf_cnt,
  output logic [IQ_PAIR_WIDTH/2-1:0] frame_seq
`ifdef IQ_PACKER_TEST_PATTERN_EN
  ,
  input  logic                       test_mode
`endif
);

  localparam int unsigned HALF_W    = IQ_PAIR_WIDTH / 2;
  localparam logic [15:0] LAST_SLOT = 16'(FRAME_LEN - 1);

  packer_state_t          state, next_state;
  logic                   pend_valid, next_pend_valid;
  logic [IQ_PAIR_WIDTH-1:0] pend_word, next_pend_word;
  // Frame slots consumed so far: written, pending or dropped samples.
  logic [15:0]            sample_cnt, next_cnt;
  logic [HALF_W-1:0]      next_seq;
  logic [1:0]             ovf_inc;
  logic [OVF_CNT_W:0]     ovf_sum;
  logic [OVF_CNT_W-1:0]   ovf_next;
  logic                   wr_req;
  logic [IQ_PAIR_WIDTH-1:0] wr_word;
  logic                   frame_done;
  logic                   slot_last;

  logic [HALF_W-1:0]      smp_i, smp_q;
  logic [IQ_PAIR_WIDTH-1:0] sample_word;
  logic [IQ_PAIR_WIDTH-1:0] header_word;

`ifdef IQ_PACKER_TEST_PATTERN_EN
  iq_test_pattern_gen #(
    .HALF_W (HALF_W)
  ) u_test_pattern (
    .test_mode  (test_mode),
    .sample_idx (sample_cnt[7:0]),
    .in_i       (s_i),
    .in_q       (s_q),
    .out_i      (smp_i),
    .out_q      (smp_q)
  );
`else
  assign smp_i = s_i;
  assign smp_q = s_q;
`endif

  assign sample_word = {smp_q, smp_i};
  assign header_word = IQ_PAIR_WIDTH'(build_header(32'(SYNC_PATTERN),
                                                   32'(frame_seq), HALF_W));

  // --------------------------------------------------------------------------
  // Next-state / output decode
  // --------------------------------------------------------------------------
  always_comb begin
    next_state      = state;
    next_pend_valid = pend_valid;
    next_pend_word  = pend_word;
    next_cnt        = sample_cnt;
    next_seq        = frame_seq;
    ovf_inc         = 2'd0;
    wr_req          = 1'b0;
    wr_word         = header_word;
    frame_done      = 1'b0;
    slot_last       = (sample_cnt == LAST_SLOT);

    if (!enable) begin
      // Stop streaming: nothing written, any sample this cycle is ignored,
      // and a frame that already produced words closes its sequence number.
      next_state      = IDLE;
      next_pend_valid = 1'b0;
      if (state == DATA || state == DROP) begin
        next_seq = frame_seq + HALF_W'(1);
      end
    end else begin
      unique case (state)
        IDLE: begin
          next_state = HDR;
          next_cnt   = '0;
        end

        HDR: begin
          if (s_valid && pend_valid) begin
            // Second sample while the header is still blocked: both the
            // pending and the new sample are lost and the frame is abandoned
            // without emitting its header.
            ovf_inc         = 2'd2;
            next_pend_valid = 1'b0;
            next_cnt        = sample_cnt + 16'd1;
            if (slot_last) begin
              frame_done = 1'b1;
            end else begin
              next_state = DROP;
            end
          end else begin
            if (s_valid) begin
              next_pend_valid = 1'b1;
              next_pend_word  = sample_word;
              next_cnt        = sample_cnt + 16'd1;
            end
            // A blocked header is simply retried; it is not a dropped word.
            if (!fifo_full) begin
              wr_req     = 1'b1;
              wr_word    = header_word;
              next_state = DATA;
            end
          end
        end

        DATA: begin
          if (pend_valid) begin
            // The pending sample already owns slot 0; flush it first.
            next_pend_valid = 1'b0;
            if (fifo_full) begin
              ovf_inc = 2'd1;
            end else begin
              wr_req  = 1'b1;
              wr_word = pend_word;
            end
            if (s_valid) begin
              // Register still occupied this cycle: the newcomer is dropped.
              ovf_inc  = ovf_inc + 2'd1;
              next_cnt = sample_cnt + 16'd1;
              if (slot_last) begin
                frame_done = 1'b1;
              end else begin
                next_state = DROP;
              end
            end else if (fifo_full) begin
              next_state = DROP;
            end
          end else if (s_valid) begin
            next_cnt = sample_cnt + 16'd1;
            if (fifo_full) begin
              ovf_inc = 2'd1;
            end else begin
              wr_req  = 1'b1;
              wr_word = sample_word;
            end
            // Overflow on the final slot goes straight to the next header.
            if (slot_last) begin
              frame_done = 1'b1;
            end else if (fifo_full) begin
              next_state = DROP;
            end
          end
        end

        DROP: begin
          if (s_valid) begin
            ovf_inc  = 2'd1;
            next_cnt = sample_cnt + 16'd1;
            if (slot_last) begin
              frame_done = 1'b1;
            end
          end
        end

        default: begin
          next_state = IDLE;
        end
      endcase

      if (frame_done) begin
        next_state = HDR;
        next_cnt   = '0;
        next_seq   = frame_seq + HALF_W'(1);
      end
    end
  end

  // Saturating overflow accumulate (up to two drops per cycle).
  assign ovf_sum  = {1'b0, ovf_cnt} + {{(OVF_CNT_W-1){1'b0}}, ovf_inc};
  assign ovf_next = ovf_sum[OVF_CNT_W] ? {OVF_CNT_W{1'b1}} : ovf_sum[OVF_CNT_W-1:0];

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_word  <= '0;
      sample_cnt <= '0;
      frame_seq  <= '0;
      ovf_cnt    <= '0;
      fifo_wr_en <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      state      <= next_state;
      pend_valid <= next_pend_valid;
      pend_word  <= next_pend_word;
      sample_cnt <= next_cnt;
      frame_seq  <= next_seq;
      ovf_cnt    <= ovf_next;
      fifo_wr_en <= wr_req;
      if (wr_req) begin
        fifo_wdata <= wr_word;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iq_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_frame_packer
// Description : Self-checking bench for iq_frame_packer (FRAME_LEN=4, 16-bit
//               words). A cycle table covers normal framing, pending-register
//               use, overflow drops and enable deassertion; hand sequences
//               cover the test pattern and counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_frame_packer;

  localparam int W  = 16;
  localparam int HW = 8;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          s_valid = 1'b0;
  logic          fifo_full = 1'b0;
  logic [HW-1:0] s_i = '0;
  logic [HW-1:0] s_q = '0;
`ifdef IQ_PACKER_TEST_PATTERN_EN
  logic          test_mode = 1'b0;
`endif
  logic          fifo_wr_en;
  logic [W-1:0]  fifo_wdata;
  logic [15:0]   ovf_cnt;
  logic [HW-1:0] frame_seq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iq_frame_packer #(
    .IQ_PAIR_WIDTH (W),
    .FRAME_LEN     (FL),
    .SYNC_PATTERN  (8'hA5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .s_valid    (s_valid),
    .s_i        (s_i),
    .s_q        (s_q),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .ovf_cnt    (ovf_cnt),
    .frame_seq  (frame_seq)
`ifdef IQ_PACKER_TEST_PATTERN_EN
    ,
    .test_mode  (test_mode)
`endif
  );

  typedef struct {
    logic        en;
    logic        sv;
    logic [7:0]  i;
    logic [7:0]  q;
    logic        full;
    logic        we;
    logic [15:0] wd;
    logic [15:0] ovf;
    logic [7:0]  seq;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit en, input bit sv, input bit [7:0] i,
                              input bit [7:0] q, input bit full, input bit we,
                              input bit [15:0] wd, input bit [15:0] ovf,
                              input bit [7:0] seq);
    vec_t v;
    v.en = en; v.sv = sv; v.i = i; v.q = q; v.full = full;
    v.we = we; v.wd = wd; v.ovf = ovf; v.seq = seq;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: actual %h required %h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    s_valid   = 1'b0;
    fifo_full = 1'b0;
    s_i       = '0;
    s_q       = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Drive one cycle of inputs, then sample the registered outputs just after
  // the clock edge.
  task automatic step(input bit en, input bit sv, input bit [7:0] i,
                      input bit [7:0] q, input bit full);
    enable = en; s_valid = sv; s_i = i; s_q = q; fifo_full = full;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr_seen;

    // ---------------- reset values ----------------
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 0, 32'(fifo_wr_en), 32'd0);
    check("rst_wdata", 0, 32'(fifo_wdata), 32'd0);
    check("rst_ovf",   0, 32'(ovf_cnt),    32'd0);
    check("rst_seq",   0, 32'(frame_seq),  32'd0);
    reset_n = 1'b1;

    // ---------------- cycle table ----------------
    //   en sv  i     q     full we wd        ovf seq
    // two clean frames
    add(1, 0, 8'h00, 8'h00, 0, 0, 16'h0000, 0, 0);
    add(1, 0, 8'h00, 8'h00, 0, 1, 16'hA500, 0, 0);
    add(1, 1, 8'h10, 8'h80, 0, 1, 16'h8010, 0, 0);
    add(1, 1, 8'h11, 8'h81, 0, 1, 16'h8111, 0, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0, 16'h0000, 0, 0);
    add(1, 1, 8'h12, 8'h82, 0, 1, 16'h8212, 0, 0);
    add(1, 1, 8'h13, 8'h83, 0, 1, 16'h8313, 0, 1);
    add(1, 0, 8'h00, 8'h00, 0, 1, 16'hA501, 0, 1);
    add(1, 1, 8'h14, 8'h84, 0, 1, 16'h8414, 0, 1);
    add(1, 1, 8'h15, 8'h85, 0, 1, 16'h8515, 0, 1);
    add(1, 1, 8'h16, 8'h86, 0, 1, 16'h8616, 0, 1);
    add(1, 1, 8'h17, 8'h87, 0, 1, 16'h8717, 0, 2);
    add(1, 0, 8'h00, 8'h00, 0, 1, 16'hA502, 0, 2);
    // enable falls after two data words, then re-enable
    add(1, 1, 8'h18, 8'h88, 0, 1, 16'h8818, 0, 2);
    add(1, 1, 8'h19, 8'h89, 0, 1, 16'h8919, 0, 2);
    add(0, 0, 8'h00, 8'h00, 0, 0, 16'h0000, 0, 3);
    add(0, 0, 8'h00, 8'h00, 0, 0, 16'h0000, 0, 3);
    add(1, 0, 8'h00, 8'h00, 0, 0, 16'h0000, 0, 3);
    add(1, 0, 8'h00, 8'h00, 0, 1, 16'hA503, 0, 3);
    // sample in the header cycle goes through the pending register
    add(1, 1, 8'h20, 8'h90, 0, 1, 16'h9020, 0, 3);
    add(1, 1, 8'h21, 8'h91, 0, 1, 16'h9121, 0, 3);
    add(1, 1, 8'h22, 8'h92, 0, 1, 16'h9222, 0, 3);
    add(1, 1, 8'h23, 8'h93, 0, 1, 16'h9323, 0, 4);
    add(1, 1, 8'h30, 8'hA0, 0, 1, 16'hA504, 0, 4);
    add(1, 0, 8'h00, 8'h00, 0, 1, 16'hA030, 0, 4);
    add(1, 1, 8'h31, 8'hA1, 0, 1, 16'hA131, 0, 4);
    add(1, 1, 8'h32, 8'hA2, 0, 1, 16'hA232, 0, 4);
    add(1, 1, 8'h33, 8'hA3, 0, 1, 16'hA333, 0, 5);
    add(1, 0, 8'h00, 8'h00, 0, 1, 16'hA505, 0, 5);
    // overflow on d2 drops d2 and d3
    add(1, 1, 8'h40, 8'hB0, 0, 1, 16'hB040, 0, 5);
    add(1, 1, 8'h41, 8'hB1, 0, 1, 16'hB141, 0, 5);
    add(1, 1, 8'h42, 8'hB2, 1, 0, 16'h0000, 1, 5);
    add(1, 1, 8'h43, 8'hB3, 0, 0, 16'h0000, 2, 6);
    add(1, 0, 8'h00, 8'h00, 0, 1, 16'hA506, 2, 6);
    // overflow on the last word goes straight to the header
    add(1, 1, 8'h44, 8'hB4, 0, 1, 16'hB444, 2, 6);
    add(1, 1, 8'h45, 8'hB5, 0, 1, 16'hB545, 2, 6);
    add(1, 1, 8'h46, 8'hB6, 0, 1, 16'hB646, 2, 6);
    add(1, 1, 8'h47, 8'hB7, 1, 0, 16'h0000, 3, 7);
    add(1, 0, 8'h00, 8'h00, 0, 1, 16'hA507, 3, 7);
    // blocked header is retried; sample meanwhile is held pending
    add(1, 1, 8'h50, 8'hC0, 0, 1, 16'hC050, 3, 7);
    add(1, 1, 8'h51, 8'hC1, 0, 1, 16'hC151, 3, 7);
    add(1, 1, 8'h52, 8'hC2, 0, 1, 16'hC252, 3, 7);
    add(1, 1, 8'h53, 8'hC3, 0, 1, 16'hC353, 3, 8);
    add(1, 0, 8'h00, 8'h00, 1, 0, 16'h0000, 3, 8);
    add(1, 1, 8'h60, 8'hD0, 1, 0, 16'h0000, 3, 8);
    add(1, 0, 8'h00, 8'h00, 0, 1, 16'hA508, 3, 8);
    add(1, 0, 8'h00, 8'h00, 0, 1, 16'hD060, 3, 8);
    // sample together with enable falling: ignored, not counted
    add(0, 1, 8'h61, 8'hD1, 0, 0, 16'h0000, 3, 9);
    add(0, 0, 8'h00, 8'h00, 0, 0, 16'h0000, 3, 9);

    foreach (vecs[k]) begin
      step(vecs[k].en, vecs[k].sv, vecs[k].i, vecs[k].q, vecs[k].full);
      check("wr_en", k, 32'(fifo_wr_en), 32'(vecs[k].we));
      if (vecs[k].we) begin
        check("wdata", k, 32'(fifo_wdata), 32'(vecs[k].wd));
      end
      check("ovf_cnt", k, 32'(ovf_cnt), 32'(vecs[k].ovf));
      check("frame_seq", k, 32'(frame_seq), 32'(vecs[k].seq));
    end

`ifdef IQ_PACKER_TEST_PATTERN_EN
    // ---------------- test pattern ----------------
    do_reset();
    test_mode = 1'b1;
    step(1, 0, 8'h00, 8'h00, 0);
    step(1, 0, 8'h00, 8'h00, 0);
    check("tp_hdr", 0, 32'(fifo_wdata), 32'hA500);
    step(1, 1, 8'h12, 8'h34, 0);
    check("tp_word", 0, 32'(fifo_wdata), 32'hFF00);
    step(1, 1, 8'h56, 8'h78, 0);
    check("tp_word", 1, 32'(fifo_wdata), 32'hFE01);
    step(1, 1, 8'h9A, 8'hBC, 0);
    check("tp_word", 2, 32'(fifo_wdata), 32'hFD02);
    test_mode = 1'b0;
`endif

    // ---------------- overflow counter saturation ----------------
    do_reset();
    enable    = 1'b1;
    s_valid   = 1'b1;
    fifo_full = 1'b1;
    wr_seen   = 0;
    for (int k = 0; k < 65700; k++) begin
      @(posedge clk);
      #1;
      if (fifo_wr_en) wr_seen++;
    end
    check("sat_ovf", 0, 32'(ovf_cnt), 32'h0000FFFF);
    check("sat_no_write", 0, 32'(wr_seen), 32'd0);
    enable  = 1'b0;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("sat_hold", 0, 32'(ovf_cnt), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iq_frame_packer.md
# iq_frame_packer

Sample-clock stage directly upstream of the FT600 write FIFO. Accepts one I/Q sample pair per `s_valid` strobe and packs it into one `{Q,I}` FIFO word. Every `FRAME_LEN` samples it prefixes a header word carrying a sync pattern and a frame sequence number. On FIFO overflow it discards the remainder of the current frame, so the host always resynchronises on a header.

## Interface
Parameters:
- `IQ_PAIR_WIDTH`, default 16: FIFO word width. I occupies the low half, Q the high half. Must be even and ≥ 8.
- `FRAME_LEN`, default 1024: data words per frame, excluding the header. Range 2..65535.
- `SYNC_PATTERN`, default 8'hA5: header upper half, zero-extended or truncated to `IQ_PAIR_WIDTH/2`.

Ports:
- `clk`, in, 1: sample clock; the FIFO write clock.
- `reset_n`, in, 1: synchronous, active-low.
- `enable`, in, 1: streaming enable.
- `s_valid`, in, 1: sample strobe, one-cycle pulse per sample.
- `s_i`, in, `IQ_PAIR_WIDTH/2`: I sample.
- `s_q`, in, `IQ_PAIR_WIDTH/2`: Q sample.
- `fifo_full`, in, 1: write FIFO full flag, write-clock domain.
- `fifo_wr_en`, out, 1: FIFO write strobe, registered.
- `fifo_wdata`, out, `IQ_PAIR_WIDTH`: FIFO write data, registered.
- `ovf_cnt`, out, 16: count of dropped words, saturating.
- `frame_seq`, out, `IQ_PAIR_WIDTH/2`: sequence number of the current frame.
- `test_mode`, in, 1: present only with `IQ_PACKER_TEST_PATTERN_EN`.

## Operation
States:
- IDLE: leave when `enable`=1, go to HDR.
- HDR: emit header word `{SYNC_PATTERN, frame_seq}`. Go to DATA. Sample counter resets to 0.
- DATA: each accepted sample writes `{s_q, s_i}`. After word `FRAME_LEN-1`, `frame_seq` increments (wraps modulo 2^(`IQ_PAIR_WIDTH/2`)) and the next state is HDR.
- DROP: samples are counted but not written; each counts toward `ovf_cnt`. When the frame's `FRAME_LEN` slots complete, `frame_seq` increments and the next state is HDR.

Pending register (1 deep):
- A sample that arrives in the HDR cycle is latched and written in the first DATA cycle.
- If the register is already occupied and a new sample arrives, the new sample is dropped, counted in `ovf_cnt`, and the FSM goes to DROP.

Overflow:
- Any required write with `fifo_full`=1 is suppressed; `ovf_cnt` increments and the FSM goes to DROP.
- A header blocked by `fifo_full` is retried each cycle in HDR. A sample arriving meanwhile goes to the pending register.
- `ovf_cnt` saturates at 16'hFFFF and clears only on reset.

`enable` deassertion in any state:
- Next state is IDLE. The pending register is cleared.
- A partial frame is not padded. `frame_seq` increments if the frame had any words.

## Timing
- Reset values: `fifo_wr_en`=0, `fifo_wdata`=0, `ovf_cnt`=0, `frame_seq`=0, state IDLE, pending empty.
- Latency from `s_valid` to `fifo_wr_en` is 1 cycle, or 2 cycles if the sample was held in the pending register.
- Header cycle: the header write occurs 1 cycle after `enable` rises, and 1 cycle after the last data word of a frame.
- `fifo_wr_en` is never asserted in a cycle where `fifo_full` was sampled high.
- Simultaneous events:
  - `s_valid` together with `enable` falling: the sample is dropped and not counted.
  - Overflow on the last word of a frame: skip DROP and go directly to HDR.

## Configuration
`IQ_PACKER_TEST_PATTERN_EN`:
- Defined: adds the `test_mode` port. With `test_mode`=1, each accepted sample is replaced by I = 8-bit-wrapped sample counter (within frame, truncated/extended to `IQ_PAIR_WIDTH/2`) and Q = ~I. Timing is identical.
- Undefined: the port is absent and data always passes through unchanged.

## Structure
- `iq_packer_pkg`: the state enum (IDLE, HDR, DATA, DROP), `OVF_CNT_W`=16, and the header build function.
- Natural sub-module: `iq_test_pattern_gen`, instantiated only under the macro.

## Test plan
1. `FRAME_LEN`=4, enable, 8 samples, FIFO never full → words H(seq0), d0..d3, H(seq1), d4..d7; `ovf_cnt`=0.
2. `fifo_full` high during d2 of frame 0 → d2 and d3 dropped, `ovf_cnt`=2; next word is H(seq1), then d4.
3. `s_valid` in the HDR cycle → header, then that sample in the next cycle, with no loss.
4. `enable` falls after d1 → FSM in IDLE. On re-enable the first word is H(seq1).
5. Force 65540 drops → `ovf_cnt`=16'hFFFF.
6. Macro defined, `test_mode`=1, `IQ_PAIR_WIDTH`=16 → data words 16'hFF00, 16'hFE01, 16'hFD02, …
